// File: rtl/mcs8_timing_pkg.sv
// State codes for the 8008-style timing generator, shared by the
// timing block, the instruction decoder and the testbench.
package mcs8_timing_pkg;

    localparam logic [2:0] S_T1      = 3'b010;
    localparam logic [2:0] S_T1I     = 3'b110;
    localparam logic [2:0] S_T2      = 3'b100;
    localparam logic [2:0] S_WAIT    = 3'b000;
    localparam logic [2:0] S_T3      = 3'b001;
    localparam logic [2:0] S_STOPPED = 3'b011;
    localparam logic [2:0] S_T4      = 3'b111;
    localparam logic [2:0] S_T5      = 3'b101;

    typedef enum logic [2:0] {
        ST_T1      = S_T1,
        ST_T1I     = S_T1I,
        ST_T2      = S_T2,
        ST_WAIT    = S_WAIT,
        ST_T3      = S_T3,
        ST_STOPPED = S_STOPPED,
        ST_T4      = S_T4,
        ST_T5      = S_T5
    } state_e;

endpackage

// File: rtl/mcs8_timing.sv
// Machine-cycle state sequencer: advances one T-state every second PH2
// pulse and drives the SYNC / S2..S0 status lines and interrupt acknowledge.
//
// state   | meaning
// T1      | address low byte out
// T1I     | interrupt-acknowledge T1 (PC not incremented)
// T2      | address high byte / cycle type out
// WAIT    | memory not ready, stretch the cycle
// T3      | data transfer
// STOPPED | halted, waiting for an interrupt
// T4      | internal execute
// T5      | internal execute, second state
module mcs8_timing
    import mcs8_timing_pkg::*;
#(
    parameter bit START_STOPPED = 1'b1
) (
    input  logic       CLK_I,
    input  logic       nRST_I,
    input  logic       PH1_I,
    input  logic       PH2_I,
    input  logic       READY_I,
    input  logic       INT_I,
    input  logic       END_CYC_I,
    input  logic       SKIP_T5_I,
    input  logic       HALT_I,
    output logic       SYNC_O,
    output logic [2:0] S_O,
    output logic       INTACK_O
);

    localparam state_e RST_STATE = START_STOPPED ? ST_STOPPED : ST_T1;

    state_e state_q, state_d, next_st;
    logic   sync_q, sync_d;
    logic   pend_q, pend_d;
    logic   armed_q, armed_d;
    logic   advance;
    state_e next_cycle;

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state_q <= RST_STATE;
            sync_q  <= 1'b0;
            pend_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
        end
    end

    // The first PH2 after reset only raises SYNC, so a state is never cut short.
    assign advance    = PH2_I & ~sync_q & armed_q;
    assign next_cycle = pend_q ? ST_T1I : ST_T1;

    always_comb begin
        next_st = state_q;
        case (state_q)
            ST_T1, ST_T1I:    next_st = ST_T2;
            ST_T2, ST_WAIT:   next_st = READY_I ? ST_T3 : ST_WAIT;
            ST_T3: begin
                if (HALT_I)         next_st = ST_STOPPED;
                else if (END_CYC_I) next_st = next_cycle;
                else                next_st = ST_T4;
            end
            ST_T4:            next_st = SKIP_T5_I ? next_cycle : ST_T5;
            ST_T5:            next_st = next_cycle;
            ST_STOPPED:       next_st = pend_q ? ST_T1I : ST_STOPPED;
            default:          next_st = RST_STATE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        armed_d = armed_q | PH2_I;
        pend_d  = pend_q;

        if (advance) begin
            state_d = next_st;
        end
        if (PH2_I) begin
            sync_d = ~sync_q;
        end
        // Acknowledging the interrupt beats a new request on the same edge.
        if (advance && (next_st == ST_T1I)) begin
            pend_d = 1'b0;
        end else if (PH1_I && INT_I) begin
            pend_d = 1'b1;
        end
    end

    assign SYNC_O   = sync_q;
    assign S_O      = state_q;
    assign INTACK_O = (state_q == ST_T1I);

endmodule

// File: tb/tb_mcs8_timing.sv
// Directed bench for mcs8_timing: two instances (start in T1 / start stopped)
// checked every cycle against a behavioural model plus literal step tables.
module tb_mcs8_timing;
    import mcs8_timing_pkg::*;

    logic CLK_I = 1'b0;
    logic nRST_I;
    logic PH1_I, PH2_I;
    logic READY_I, INT_I, END_CYC_I, SKIP_T5_I, HALT_I;
    logic ph_en = 1'b1;
    int   ph_cnt;

    logic       sync0, sync1, ack0, ack1;
    logic [2:0] s0, s1;

    int n_chk  = 0;
    int n_fail = 0;

    mcs8_timing #(.START_STOPPED(1'b0)) dut0 (
        .CLK_I(CLK_I), .nRST_I(nRST_I), .PH1_I(PH1_I), .PH2_I(PH2_I),
        .READY_I(READY_I), .INT_I(INT_I), .END_CYC_I(END_CYC_I),
        .SKIP_T5_I(SKIP_T5_I), .HALT_I(HALT_I),
        .SYNC_O(sync0), .S_O(s0), .INTACK_O(ack0)
    );

    mcs8_timing dut1 (
        .CLK_I(CLK_I), .nRST_I(nRST_I), .PH1_I(PH1_I), .PH2_I(PH2_I),
        .READY_I(READY_I), .INT_I(INT_I), .END_CYC_I(END_CYC_I),
        .SKIP_T5_I(SKIP_T5_I), .HALT_I(HALT_I),
        .SYNC_O(sync1), .S_O(s1), .INTACK_O(ack1)
    );

    always #5 CLK_I = ~CLK_I;

    // Four-cycle two-phase clock: PH1 in slot 0, PH2 in slot 2.
    initial begin
        ph_cnt = 0;
        PH1_I  = 1'b0;
        PH2_I  = 1'b0;
        forever begin
            @(negedge CLK_I);
            PH1_I  = ph_en && (ph_cnt == 0);
            PH2_I  = ph_en && (ph_cnt == 2);
            ph_cnt = (ph_cnt + 1) % 4;
        end
    end

    // ---------------- behavioural model ----------------
    logic [2:0] m_code [2];
    logic       m_sync [2];
    logic       m_pend [2];
    logic       m_seen_ph2 [2];

    function automatic logic [2:0] rule_next(input logic [2:0] cur, input logic pend,
                                             input logic rdy, input logic halt,
                                             input logic endc, input logic skip);
        logic [2:0] after_cycle;
        after_cycle = pend ? S_T1I : S_T1;
        if (cur == S_T1 || cur == S_T1I) return S_T2;
        if (cur == S_T2 || cur == S_WAIT) return rdy ? S_T3 : S_WAIT;
        if (cur == S_T3) return halt ? S_STOPPED : (endc ? after_cycle : S_T4);
        if (cur == S_T4) return skip ? after_cycle : S_T5;
        if (cur == S_T5) return after_cycle;
        return pend ? S_T1I : S_STOPPED;
    endfunction

    always @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            m_code[0] = S_T1;
            m_code[1] = S_STOPPED;
            for (int i = 0; i < 2; i++) begin
                m_sync[i] = 1'b0; m_pend[i] = 1'b0; m_seen_ph2[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic adv;
                logic [2:0] nxt;
                adv = PH2_I && !m_sync[i] && m_seen_ph2[i];
                nxt = rule_next(m_code[i], m_pend[i], READY_I, HALT_I, END_CYC_I, SKIP_T5_I);
                if (PH1_I && INT_I) m_pend[i] = 1'b1;
                if (adv) begin
                    if (nxt == S_T1I) m_pend[i] = 1'b0;
                    m_code[i] = nxt;
                end
                if (PH2_I) begin
                    m_sync[i] = !m_sync[i];
                    m_seen_ph2[i] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge CLK_I) begin
        if (nRST_I === 1'b1) begin
            check("m_s0",    {29'd0, s0},    {29'd0, m_code[0]});
            check("m_sync0", {31'd0, sync0}, {31'd0, m_sync[0]});
            check("m_ack0",  {31'd0, ack0},  {31'd0, (m_code[0] == S_T1I)});
            check("m_s1",    {29'd0, s1},    {29'd0, m_code[1]});
            check("m_sync1", {31'd0, sync1}, {31'd0, m_sync[1]});
            check("m_ack1",  {31'd0, ack1},  {31'd0, (m_code[1] == S_T1I)});
        end
    end

    // ---------------- directed steps ----------------
    int adv_no = 0;

    task automatic wait_rise(output int cyc);
        logic prev, now;
        prev = sync0;
        cyc  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK_I); #1;
            cyc++;
            now = sync0;
            if (now && !prev) return;
            prev = now;
        end
        n_chk++;
        n_fail++;
        $display("FAIL adv_timeout: no SYNC rise within 40 cycles, got none expected one");
    endtask

    task automatic step(input logic [2:0] e0, input logic [2:0] e1, input int e_cyc);
        int cyc;
        wait_rise(cyc);
        adv_no++;
        check($sformatf("adv%0d_s0", adv_no), {29'd0, s0}, {29'd0, e0});
        check($sformatf("adv%0d_s1", adv_no), {29'd0, s1}, {29'd0, e1});
        if (e_cyc > 0) check($sformatf("adv%0d_len", adv_no), cyc, e_cyc);
    endtask

    task automatic int_pulse();
        INT_I = 1'b1;
        repeat (4) @(posedge CLK_I);
        #1 INT_I = 1'b0;
    endtask

    initial begin
        int cyc;
        nRST_I = 1'b0;
        READY_I = 1'b1; END_CYC_I = 1'b1; SKIP_T5_I = 1'b0; HALT_I = 1'b0; INT_I = 1'b0;
        repeat (3) @(posedge CLK_I);
        #2;
        check("rst_s0",    {29'd0, s0}, 32'h2);
        check("rst_s1",    {29'd0, s1}, 32'h3);
        check("rst_sync0", {31'd0, sync0}, 32'h0);
        check("rst_ack1",  {31'd0, ack1}, 32'h0);
        @(negedge CLK_I); #1 nRST_I = 1'b1;

        wait_rise(cyc);
        check("first_ph2_s0", {29'd0, s0}, 32'h2);
        check("first_ph2_s1", {29'd0, s1}, 32'h3);

        step(3'b100, 3'b011, 0);
        step(3'b001, 3'b011, 8);
        step(3'b010, 3'b011, 8);
        step(3'b100, 3'b011, 8);
        READY_I = 1'b0;
        step(3'b000, 3'b011, 8);
        step(3'b000, 3'b011, 8);
        step(3'b000, 3'b011, 8);
        READY_I = 1'b1;
        step(3'b001, 3'b011, 8);
        END_CYC_I = 1'b0;
        step(3'b111, 3'b011, 0);
        step(3'b101, 3'b011, 0);
        step(3'b010, 3'b011, 0);
        step(3'b100, 3'b011, 0);
        step(3'b001, 3'b011, 0);
        SKIP_T5_I = 1'b1;
        step(3'b111, 3'b011, 0);
        step(3'b010, 3'b011, 0);
        SKIP_T5_I = 1'b0; END_CYC_I = 1'b1;
        int_pulse();
        step(3'b100, 3'b110, 0);
        check("ack1_t1i", {31'd0, ack1}, 32'h1);
        check("ack0_t2",  {31'd0, ack0}, 32'h0);
        step(3'b001, 3'b100, 0);
        check("ack1_t2",  {31'd0, ack1}, 32'h0);
        step(3'b110, 3'b001, 0);
        check("ack0_t1i", {31'd0, ack0}, 32'h1);
        step(3'b100, 3'b010, 0);
        step(3'b001, 3'b100, 0);
        HALT_I = 1'b1;
        step(3'b011, 3'b001, 0);
        step(3'b011, 3'b011, 0);
        HALT_I = 1'b0;
        int_pulse();
        step(3'b110, 3'b110, 0);
        step(3'b100, 3'b100, 0);
        int_pulse();
        step(3'b001, 3'b001, 0);
        step(3'b110, 3'b110, 0);
        step(3'b100, 3'b100, 0);

        ph_en = 1'b0;
        repeat (60) @(posedge CLK_I);
        #1;
        check("hold_s0",   {29'd0, s0}, 32'h4);
        check("hold_s1",   {29'd0, s1}, 32'h4);
        check("hold_sync", {31'd0, sync0}, 32'h1);
        ph_en = 1'b1;

        END_CYC_I = 1'b0;
        step(3'b001, 3'b001, 0);
        step(3'b111, 3'b111, 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK_I); #1;
            if (!sync0) break;
        end
        check("t4_second_half", {31'd0, sync0}, 32'h0);
        @(negedge CLK_I); #2 nRST_I = 1'b0;
        #1;
        check("mid_rst_s0",   {29'd0, s0}, 32'h2);
        check("mid_rst_s1",   {29'd0, s1}, 32'h3);
        check("mid_rst_sync", {31'd0, sync1}, 32'h0);
        check("mid_rst_ack",  {31'd0, ack0 | ack1}, 32'h0);
        repeat (3) @(posedge CLK_I);
        #3 nRST_I = 1'b1;
        wait_rise(cyc);
        check("rel_ph2_s0", {29'd0, s0}, 32'h2);
        check("rel_ph2_s1", {29'd0, s1}, 32'h3);
        step(3'b100, 3'b011, 0);

        repeat (2) @(posedge CLK_I);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
